alu181_sliced: RTL and testbench
================================

// Module: alu181_sliced
// PURPOSE
//  Parametrised, multi-cycle successor to the 16-bit 74181-style datapath ALU.
//  - Evaluates the full 74181 function set (S[3:0], M, carry-in) over WIDTH bits, SLICE bits per clock, LSB first.
//  - Carries ripple between slices through a register, so cost is one SLICE-wide adder.
//  - Adds a valid/ready handshake, registered result and status flags; sits between operand mux and writeback.
// PARAMETERS
//  WIDTH       16  operand/result width; WIDTH % SLICE == 0 (elaboration error otherwise)
//  SLICE       4   bits processed per cycle; SLICE == WIDTH gives single-cycle operation
//  LOGIC_FAST  1   1: logic ops (M=1) complete in one BUSY cycle; 0: logic ops take NSLICE cycles like arithmetic
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block can accept; high only in IDLE
//  s          in   4      74181 function select
//  m          in   1      1 = logic mode, 0 = arithmetic mode
//  cin        in   1      active-high carry-in (arithmetic only)
//  a, b       in   WIDTH  operands
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts the result
//  y          out  WIDTH  result
//  cout       out  1      carry out of MSB; 0 in logic mode
//  zero       out  1      y == 0
//  neg        out  1      y[WIDTH-1]
//  ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB; 0 in logic mode
// BEHAVIOUR
//  - Per bit: T1 = a | (b&s0) | (~b&s1); T2 = (a&~b&s2) | (a&b&s3).
//    - Arithmetic: y = T1 + T2 + cin, mod 2^WIDTH; cout = bit WIDTH of the sum.
//    - Logic: y = ~(T1 ^ T2).
//    - Examples: S=1001 M=0 is A+B; S=0110 M=0 is A-B-1+cin; S=1001 M=1 is XNOR; S=0000 M=1 is ~A.
//  - FSM IDLE -> BUSY -> DONE -> IDLE. NSLICE = WIDTH/SLICE; slice counter is $clog2(NSLICE) bits, minimum 1.
//    - IDLE: in_ready=1. On in_valid: latch s, m, cin, a, b; clear counter; carry reg <= cin (0 if m); go BUSY.
//    - BUSY: each cycle, slice k of y <= slice result and carry reg <= slice carry; k++.
//      - After slice NSLICE-1, go DONE.
//      - If LOGIC_FAST=1 and m=1, all slices are written in the first BUSY cycle, then DONE.
//    - DONE: out_valid=1, flags valid. On out_ready, go IDLE; the next accept happens no earlier than the following cycle.
//  - Latency: out_valid rises NSLICE edges after the accept edge; 1 edge for fast logic ops. Throughput is 1 op per NSLICE+2 cycles.
//  - ovf: register the carry into the MSB during the last slice.
//  - zero/neg/ovf/cout are registered at the DONE transition; they never glitch while out_valid=1.
//  - Backpressure: y and flags hold stable while out_valid && !out_ready.
//    - in_ready stays 0 in BUSY/DONE; in_valid is ignored there.
//    - Input changes after acceptance do not affect the result.
//  - Reset (any state, including mid-BUSY): state=IDLE; y, cout, zero, neg, ovf, out_valid, counter and carry reg = 0.
//    in_ready=1 from the first cycle after rst_n deasserts.
//  - zero resets to 0, not 1.
// STRUCTURE
//  - alu181_pkg:
//    - state enum {ST_IDLE, ST_BUSY, ST_DONE}
//    - select localparams ALU_ADD=4'b1001, ALU_SUB=4'b0110, ALU_PASSA=4'b0000, ALU_DEC=4'b1111
//  - Sub-module alu181_slice #(SLICE): combinational T1/T2 generation, SLICE-bit sum, carry-in/carry-out, MSB-carry-in tap, logic output.
//    - LOGIC_FAST instantiates its logic path across the full WIDTH with no carry.
//  - Top level holds the FSM, counter, carry reg and result/flag registers.
// TESTING (WIDTH=16, SLICE=4, LOGIC_FAST=1 unless stated)
//  1 ADD S=1001 M=0 cin=0 a=16'h1234 b=16'h4321 -> y=16'h5555, cout=0, zero=0; out_valid exactly 4 edges after accept.
//  2 Ripple: ADD a=16'hFFFF b=16'h0001 -> y=16'h0000, cout=1, zero=1, ovf=0 (carry crosses all 4 slices).
//  3 SUB S=0110 M=0 cin=1 a=16'h8000 b=16'h0001 -> y=16'h7FFF, cout=1, ovf=1, neg=0.
//  4 XNOR S=1001 M=1 a=16'hF0F0 b=16'hFF00 -> y=16'hF00F, cout=0, ovf=0, neg=1; latency 1 edge; repeat with LOGIC_FAST=0 -> 4 edges.
//  5 Backpressure: hold out_ready=0 for 3 cycles after out_valid, pulse in_valid with new operands -> y/flags unchanged, in_ready=0, no second op; accept resumes after out_ready.
//  6 Reset mid-BUSY: assert rst_n=0 after 2 slices -> all outputs 0 immediately (async); after release in_ready=1, next ADD returns the correct result.

Source files
------------

// File: rtl/alu181_sliced_pkg.sv
// alu181_pkg: shared types and constants for the bit-sliced 74181-style ALU.
package alu181_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  // Frequently used 74181 function selects
  localparam logic [3:0] ALU_ADD   = 4'b1001;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_DEC   = 4'b1111;

  // Width of a counter that must index n slices; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu181_sliced_if.sv
// alu181_sliced_if: request/response bundle between the operand mux and the ALU.
interface alu181_sliced_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       s;
  logic             m;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, s, m, cin, a, b, out_ready,
    input  in_ready, out_valid, y, cout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, s, m, cin, a, b, out_ready,
    output in_ready, out_valid, y, cout, zero, neg, ovf
  );
endinterface

// File: rtl/alu181_sliced_slice.sv
// alu181_slice: combinational 74181 cell array for SLICE bits.
// Produces the arithmetic sum with carry chain, the logic-mode result and
// the carry that entered the slice's top bit (used for signed overflow).
module alu181_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [3:0]       s,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic [SLICE-1:0] lgc,
  output logic             cout,
  output logic             cmsb
);
  logic [SLICE-1:0] t1;
  logic [SLICE-1:0] t2;
  logic [SLICE:0]   full;

  assign t1   = a | (b & {SLICE{s[0]}}) | (~b & {SLICE{s[1]}});
  assign t2   = (a & ~b & {SLICE{s[2]}}) | (a & b & {SLICE{s[3]}});
  assign lgc  = ~(t1 ^ t2);
  assign full = {1'b0, t1} + {1'b0, t2} + {{SLICE{1'b0}}, cin};
  assign sum  = full[SLICE-1:0];
  assign cout = full[SLICE];
  // The top sum bit is t1^t2^carry_in, so the carry in can be recovered from it
  assign cmsb = sum[SLICE-1] ^ t1[SLICE-1] ^ t2[SLICE-1];
endmodule

// File: rtl/alu181_sliced.sv
// alu181_sliced: multi-cycle 74181-style ALU processing SLICE bits per clock,
// LSB first, with the inter-slice carry held in a register. Results and flags
// are registered and presented through a valid/ready handshake.
module alu181_sliced
  import alu181_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter int LOGIC_FAST = 1
) (
  input logic            clk,
  input logic            rst_n,
  alu181_sliced_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_width(NSLICE);

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("alu181_sliced: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [3:0]       s_r;
  logic             m_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] y_nx;
  logic             cout_r;
  logic             zero_r;
  logic             neg_r;
  logic             ovf_r;
  logic             accept;
  logic             step;
  logic             finish;
  logic             last;
  logic             fast;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] sum_sl;
  logic [SLICE-1:0] lgc_sl;
  logic             cout_sl;
  logic             cmsb_sl;
  logic [WIDTH-1:0] lgc_full;

  assign fast = (LOGIC_FAST != 0) && m_r;
  assign last = (cnt == CW'(NSLICE - 1));
  assign a_sl = a_r[int'(cnt)*SLICE +: SLICE];
  assign b_sl = b_r[int'(cnt)*SLICE +: SLICE];

  alu181_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .s    (s_r),
    .cin  (carry),
    .sum  (sum_sl),
    .lgc  (lgc_sl),
    .cout (cout_sl),
    .cmsb (cmsb_sl)
  );

  // The fast logic path only needs the carry-free logic output across the full word
  if (LOGIC_FAST != 0) begin : g_fast
    logic [WIDTH-1:0] unused_sum;
    logic             unused_cout;
    logic             unused_cmsb;
    alu181_slice #(.SLICE(WIDTH)) u_full (
      .a    (a_r),
      .b    (b_r),
      .s    (s_r),
      .cin  (1'b0),
      .sum  (unused_sum),
      .lgc  (lgc_full),
      .cout (unused_cout),
      .cmsb (unused_cmsb)
    );
  end else begin : g_no_fast
    assign lgc_full = '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (fast || last) begin
          finish   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Result word with the current slice (or the whole fast logic word) merged in
  always_comb begin
    y_nx = y_r;
    if (fast) y_nx = lgc_full;
    else if (m_r) y_nx[int'(cnt)*SLICE +: SLICE] = lgc_sl;
    else y_nx[int'(cnt)*SLICE +: SLICE] = sum_sl;
  end

  // Operand capture, slice stepping and flag registration on the final slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      s_r    <= '0;
      m_r    <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      y_r    <= '0;
      cout_r <= 1'b0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      s_r   <= bus.s;
      m_r   <= bus.m;
      a_r   <= bus.a;
      b_r   <= bus.b;
      cnt   <= '0;
      carry <= bus.m ? 1'b0 : bus.cin;
    end else if (step) begin
      y_r   <= y_nx;
      cnt   <= cnt + 1'b1;
      carry <= m_r ? 1'b0 : cout_sl;
      if (finish) begin
        cout_r <= m_r ? 1'b0 : cout_sl;
        ovf_r  <= m_r ? 1'b0 : (cmsb_sl ^ cout_sl);
        zero_r <= (y_nx == '0);
        neg_r  <= y_nx[WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.y         = y_r;
  assign bus.cout      = cout_r;
  assign bus.zero      = zero_r;
  assign bus.neg       = neg_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_alu181_sliced.sv
// tb_alu181_sliced: scoreboard bench driving two ALUs in lockstep, one with the
// fast logic path and one without, against a whole-word reference model.
module tb_alu181_sliced;
  import alu181_pkg::*;

  typedef struct packed {
    logic [15:0] y;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  op_s = '0;
  logic        op_m = 1'b0;
  logic        op_cin = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        out_ready = 1'b0;
  logic        hold_ready = 1'b1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   seen[2];

  alu181_sliced_if #(.WIDTH(16)) bus0 ();
  alu181_sliced_if #(.WIDTH(16)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.s         = op_s;
  assign bus0.m         = op_m;
  assign bus0.cin       = op_cin;
  assign bus0.a         = op_a;
  assign bus0.b         = op_b;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.s         = op_s;
  assign bus1.m         = op_m;
  assign bus1.cin       = op_cin;
  assign bus1.a         = op_a;
  assign bus1.b         = op_b;
  assign bus1.out_ready = out_ready;

  alu181_sliced #(.WIDTH(16), .SLICE(4), .LOGIC_FAST(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  alu181_sliced #(.WIDTH(16), .SLICE(4), .LOGIC_FAST(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure accept-to-valid latency
  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer backpressure unless a test is holding out_ready itself
  always @(negedge clk) begin
    if (!hold_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Reference: the 74181 rules evaluated on whole words with plain arithmetic
  function automatic exp_t model(input logic [3:0] s, input logic m, input logic cin,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input int lat, input int acc);
    exp_t        e;
    logic [15:0] t1;
    logic [15:0] t2;
    logic [16:0] sum;
    logic [15:0] low;
    t1 = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
    t2 = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
    e = '0;
    if (m) begin
      e.y    = ~(t1 ^ t2);
      e.cout = 1'b0;
      e.ovf  = 1'b0;
    end else begin
      sum    = {1'b0, t1} + {1'b0, t2} + 17'(cin);
      low    = {1'b0, t1[14:0]} + {1'b0, t2[14:0]} + 16'(cin);
      e.y    = sum[15:0];
      e.cout = sum[16];
      e.ovf  = low[15] ^ sum[16];
    end
    e.zero = (e.y == 16'h0000);
    e.neg  = e.y[15];
    e.lat  = lat;
    e.acc  = acc;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Issue one operation to both ALUs and record the expected responses
  task automatic applyStimulus(input logic [3:0] s, input logic m, input logic cin,
                               input logic [15:0] a, input logic [15:0] b);
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!(bus0.in_ready && bus1.in_ready) && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (wait_cnt >= 200) begin
      fail_now("in_ready wait");
      return;
    end
    op_s     = s;
    op_m     = m;
    op_cin   = cin;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    q0.push_back(model(s, m, cin, a, b, m ? 1 : 4, cyc + 1));
    q1.push_back(model(s, m, cin, a, b, 4, cyc + 1));
    @(negedge clk);
    in_valid = 1'b0;
    op_s     = 4'($urandom);
    op_m     = 1'($urandom);
    op_cin   = 1'($urandom);
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
  endtask

  task automatic drain();
    int wait_cnt;
    wait_cnt = 0;
    while ((q0.size() != 0 || q1.size() != 0) && wait_cnt < 300) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (wait_cnt >= 300) fail_now("drain");
  endtask

  // Compare whatever one ALU presents against the head of its queue
  task automatic checkOutput(input int idx);
    logic        v;
    logic        ir;
    logic [15:0] yy;
    logic [3:0]  fl;
    bit          have;
    exp_t        e;
    e = '0;
    if (idx == 0) begin
      v = bus0.out_valid; ir = bus0.in_ready; yy = bus0.y;
      fl = {bus0.cout, bus0.zero, bus0.neg, bus0.ovf};
      have = (q0.size() != 0);
      if (have) e = q0[0];
    end else begin
      v = bus1.out_valid; ir = bus1.in_ready; yy = bus1.y;
      fl = {bus1.cout, bus1.zero, bus1.neg, bus1.ovf};
      have = (q1.size() != 0);
      if (have) e = q1[0];
    end
    if (!v) return;
    check($sformatf("dut%0d in_ready while out_valid", idx), 32'(ir), 32'd0);
    if (!have) begin
      n_chk++;
      n_fail++;
      $display("[TB] FAIL dut%0d unexpected result: got y=%h with nothing pending (t=%0t)",
               idx, yy, $time);
      return;
    end
    if (!seen[idx]) begin
      check($sformatf("dut%0d latency", idx), 32'(cyc - e.acc), 32'(e.lat));
      seen[idx] = 1'b1;
    end
    check($sformatf("dut%0d y", idx), 32'(yy), 32'(e.y));
    check($sformatf("dut%0d flags cout/zero/neg/ovf", idx), 32'(fl),
          32'({e.cout, e.zero, e.neg, e.ovf}));
    if (out_ready) begin
      if (idx == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
      seen[idx] = 1'b0;
    end
  endtask

  // Monitor: samples both ALUs just after each falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        checkOutput(0);
        checkOutput(1);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  logic [15:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", 32'({bus0.out_valid, bus1.out_valid}), 32'd0);
    check("reset y", 32'({bus0.y, bus1.y}), 32'd0);
    check("reset flags", 32'({bus0.cout, bus0.zero, bus0.neg, bus0.ovf,
                              bus1.cout, bus1.zero, bus1.neg, bus1.ovf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready after reset", 32'({bus0.in_ready, bus1.in_ready}), 32'b11);
    hold_ready = 1'b0;

    applyStimulus(ALU_ADD, 1'b0, 1'b0, 16'h1234, 16'h4321);
    applyStimulus(ALU_ADD, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    applyStimulus(ALU_SUB, 1'b0, 1'b1, 16'h8000, 16'h0001);
    applyStimulus(4'b1001, 1'b1, 1'b0, 16'hF0F0, 16'hFF00);
    applyStimulus(ALU_PASSA, 1'b1, 1'b1, 16'h00FF, 16'h1234);
    applyStimulus(ALU_DEC, 1'b0, 1'b0, 16'h0000, 16'h5A5A);
    drain();

    // Backpressure: result held while the consumer stalls; new requests ignored
    @(negedge clk);
    hold_ready = 1'b1;
    out_ready  = 1'b0;
    applyStimulus(ALU_ADD, 1'b0, 1'b1, 16'h7FFF, 16'h0000);
    begin
      int w;
      w = 0;
      while (!(bus0.out_valid && bus1.out_valid) && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) fail_now("backpressure out_valid wait");
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_s     = ALU_SUB;
      op_m     = 1'b0;
      op_cin   = 1'b0;
      op_a     = 16'($urandom);
      op_b     = 16'($urandom);
      in_valid = 1'b1;
      #1;
      check("in_ready during backpressure", 32'({bus0.in_ready, bus1.in_ready}), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    hold_ready = 1'b0;
    drain();
    applyStimulus(ALU_ADD, 1'b0, 1'b0, 16'h0F0F, 16'h0101);
    drain();

    // Randomized operations with occasional corner operands
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      applyStimulus(4'($urandom), 1'($urandom), 1'($urandom), ra, rb);
    end
    drain();

    // Reset in the middle of a multi-slice operation
    @(negedge clk);
    begin
      int w;
      w = 0;
      while (!(bus0.in_ready && bus1.in_ready) && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) fail_now("pre-reset in_ready wait");
    end
    op_s     = ALU_ADD;
    op_m     = 1'b0;
    op_cin   = 1'b0;
    op_a     = 16'h1234;
    op_b     = 16'h4321;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    #1;
    check("mid-busy reset y", 32'({bus0.y, bus1.y}), 32'd0);
    check("mid-busy reset out_valid/flags",
          32'({bus0.out_valid, bus0.cout, bus0.zero, bus0.neg, bus0.ovf,
               bus1.out_valid, bus1.cout, bus1.zero, bus1.neg, bus1.ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready after mid-busy reset", 32'({bus0.in_ready, bus1.in_ready}), 32'b11);
    applyStimulus(ALU_ADD, 1'b0, 1'b0, 16'h1234, 16'h4321);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
